// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths, op encodings and payload types for the shifter arbiter
package shift_pkg;

  localparam int W  = 32;
  localparam int SW = 5;

  // Op bit positions within {rotate,left,arith}
  localparam int OP_ROT   = 2;
  localparam int OP_LEFT  = 1;
  localparam int OP_ARITH = 0;

  typedef enum logic [2:0] {
    SRL = 3'b000,
    SRA = 3'b001,
    SLL = 3'b010,
    SLA = 3'b011,
    ROR = 3'b100,
    ROL = 3'b110
  } shift_op_e;

  // Operands as presented to the shifter
  typedef struct packed {
    logic [W-1:0]  a;
    logic [SW-1:0] b;
    logic [2:0]    op;
  } shift_req_t;

  // Result as returned by the shifter and held for a requester
  typedef struct packed {
    logic [W-1:0] q;
    logic         ov;
    logic         z;
  } shift_rsp_t;

endpackage

// File: rtl/shift_rsp_slot.sv
// rtl/shift_rsp_slot.sv - single-entry response holding register with load/drain handshake
module shift_rsp_slot
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  shift_rsp_t load_data,
  input  logic       rsp_ready,
  output logic       rsp_valid,
  output shift_rsp_t rsp_data,
  output logic       free
);

  // The slot can accept a new result when empty or when being drained this cycle
  assign free = ~rsp_valid | rsp_ready;

  // Load wins over drain so a drained slot can be refilled at the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_arb_2.sv
// rtl/shift_arb_2.sv - two-requester round-robin sequencer for a shared 32-bit barrel shifter
module shift_arb_2
  import shift_pkg::*;
#(
  parameter bit IDLE_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req_valid,
  output logic          r0_req_ready,
  input  logic [W-1:0]  r0_req_a,
  input  logic [SW-1:0] r0_req_b,
  input  logic [2:0]    r0_req_op,
  output logic          r0_rsp_valid,
  input  logic          r0_rsp_ready,
  output logic [W-1:0]  r0_rsp_q,
  output logic          r0_rsp_ov,
  output logic          r0_rsp_z,
  input  logic          r1_req_valid,
  output logic          r1_req_ready,
  input  logic [W-1:0]  r1_req_a,
  input  logic [SW-1:0] r1_req_b,
  input  logic [2:0]    r1_req_op,
  output logic          r1_rsp_valid,
  input  logic          r1_rsp_ready,
  output logic [W-1:0]  r1_rsp_q,
  output logic          r1_rsp_ov,
  output logic          r1_rsp_z,
  output logic [W-1:0]  sh_a,
  output logic [SW-1:0] sh_b,
  output logic          sh_rotate,
  output logic          sh_left,
  output logic          sh_arith,
  input  logic [W-1:0]  sh_q,
  input  logic          sh_ov,
  input  logic          sh_z
);

  shift_req_t req0, req1;
  shift_req_t held;
  shift_req_t drive;
  shift_rsp_t sh_rsp;
  shift_rsp_t rsp0, rsp1;
  logic       free0, free1;
  logic       elig0, elig1;
  logic       grant0, grant1;
  logic       rr_ptr;   // 0: requester 0 wins a tie, 1: requester 1 wins a tie

  assign req0   = {r0_req_a, r0_req_b, r0_req_op};
  assign req1   = {r1_req_a, r1_req_b, r1_req_op};
  assign sh_rsp = {sh_q, sh_ov, sh_z};

  // A requester competes only if its response slot can take the result
  assign elig0 = r0_req_valid & free0;
  assign elig1 = r1_req_valid & free1;

  // Tie goes to the pointer; a lone eligible requester always wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = ~rr_ptr;
      grant1 = rr_ptr;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign r0_req_ready = grant0;
  assign r1_req_ready = grant1;

  // Pointer moves to the other requester after every grant, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (grant0) begin
      rr_ptr <= 1'b1;
    end else if (grant1) begin
      rr_ptr <= 1'b0;
    end
  end

  // Remember the last granted operands for the hold-when-idle drive mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= '0;
    end else if (grant0) begin
      held <= req0;
    end else if (grant1) begin
      held <= req1;
    end
  end

  // Shifter operand mux: granted requester, else zero or held operands
  always_comb begin
    drive = held;
    if (grant0) begin
      drive = req0;
    end else if (grant1) begin
      drive = req1;
    end else if (IDLE_ZERO) begin
      drive = '0;
    end
  end

  assign sh_a      = drive.a;
  assign sh_b      = drive.b;
  assign sh_rotate = drive.op[OP_ROT];
  assign sh_left   = drive.op[OP_LEFT];
  assign sh_arith  = drive.op[OP_ARITH];

  shift_rsp_slot u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant0),
    .load_data (sh_rsp),
    .rsp_ready (r0_rsp_ready),
    .rsp_valid (r0_rsp_valid),
    .rsp_data  (rsp0),
    .free      (free0)
  );

  shift_rsp_slot u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant1),
    .load_data (sh_rsp),
    .rsp_ready (r1_rsp_ready),
    .rsp_valid (r1_rsp_valid),
    .rsp_data  (rsp1),
    .free      (free1)
  );

  assign r0_rsp_q  = rsp0.q;
  assign r0_rsp_ov = rsp0.ov;
  assign r0_rsp_z  = rsp0.z;
  assign r1_rsp_q  = rsp1.q;
  assign r1_rsp_ov = rsp1.ov;
  assign r1_rsp_z  = rsp1.z;

endmodule

// File: tb/tb_shift_arb_2.sv
// tb/tb_shift_arb_2.sv - self-checking bench for shift_arb_2 with a behavioural shifter
module tb_shift_arb_2;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_ov, r0_rsp_z;
  logic [31:0] r0_req_a, r0_rsp_q;
  logic [4:0]  r0_req_b;
  logic [2:0]  r0_req_op;
  logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_ov, r1_rsp_z;
  logic [31:0] r1_req_a, r1_rsp_q;
  logic [4:0]  r1_req_b;
  logic [2:0]  r1_req_op;
  logic [31:0] sh_a, sh_q;
  logic [4:0]  sh_b;
  logic        sh_rotate, sh_left, sh_arith, sh_ov, sh_z;
  logic [63:0] dbl;

  int n_tests = 0;
  int n_fail  = 0;

  logic        mv0 = 1'b0, mv1 = 1'b0, mptr = 1'b0;
  logic        last_g0 = 1'b0, last_g1 = 1'b0;
  logic        ov_en0 = 1'b0, ov_en1 = 1'b0;
  logic [33:0] ov_val0 = '0, ov_val1 = '0;
  logic [33:0] exp0[$];
  logic [33:0] exp1[$];

  always #5 clk = ~clk;

  shift_arb_2 #(.IDLE_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_a(r0_req_a),
    .r0_req_b(r0_req_b), .r0_req_op(r0_req_op), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r0_rsp_q(r0_rsp_q), .r0_rsp_ov(r0_rsp_ov), .r0_rsp_z(r0_rsp_z),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_a(r1_req_a),
    .r1_req_b(r1_req_b), .r1_req_op(r1_req_op), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_ready(r1_rsp_ready), .r1_rsp_q(r1_rsp_q), .r1_rsp_ov(r1_rsp_ov), .r1_rsp_z(r1_rsp_z),
    .sh_a(sh_a), .sh_b(sh_b), .sh_rotate(sh_rotate), .sh_left(sh_left), .sh_arith(sh_arith),
    .sh_q(sh_q), .sh_ov(sh_ov), .sh_z(sh_z)
  );

  // Behavioural stand-in for the external combinational barrel shifter
  always_comb begin
    dbl   = {sh_a, sh_a};
    sh_ov = 1'b0;
    if (sh_rotate) begin
      if (sh_left) begin
        dbl  = dbl << sh_b;
        sh_q = dbl[63:32];
      end else begin
        dbl  = dbl >> sh_b;
        sh_q = dbl[31:0];
      end
    end else if (sh_left) begin
      sh_q = sh_a << sh_b;
      if (sh_arith) sh_ov = (($signed(sh_q) >>> sh_b) != $signed(sh_a));
    end else if (sh_arith) begin
      sh_q = $signed(sh_a) >>> sh_b;
    end else begin
      sh_q = sh_a >> sh_b;
    end
    sh_z = (sh_q == 32'd0);
  end

  // Bit-at-a-time reference for expected {q,ov,z}
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [4:0] b,
                                         input logic [2:0] op);
    logic [31:0] q;
    logic        ov;
    q  = a;
    ov = 1'b0;
    for (int i = 0; i < int'(b); i++) begin
      if (op[2]) q = op[1] ? {q[30:0], q[31]} : {q[0], q[31:1]};
      else if (op[1]) begin
        if (op[0] && (q[31] != q[30])) ov = 1'b1;
        q = {q[30:0], 1'b0};
      end else q = {op[0] & q[31], q[31:1]};
    end
    return {q, ov, q == 32'd0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    mv0 = 1'b0; mv1 = 1'b0; mptr = 1'b0;
    exp0.delete(); exp1.delete();
    ov_en0 = 1'b0; ov_en1 = 1'b0;
  endtask

  // One clock: check grants, shifter drive and responses, then advance
  task automatic tick();
    logic e0, e1, g0, g1;
    #1;
    e0 = r0_req_valid & (~mv0 | r0_rsp_ready);
    e1 = r1_req_valid & (~mv1 | r1_rsp_ready);
    g0 = e0 & (~e1 | ~mptr);
    g1 = e1 & (~e0 | mptr);
    chk("r0_req_ready", 64'(r0_req_ready), 64'(g0));
    chk("r1_req_ready", 64'(r1_req_ready), 64'(g1));
    chk("r0_rsp_valid", 64'(r0_rsp_valid), 64'(mv0));
    chk("r1_rsp_valid", 64'(r1_rsp_valid), 64'(mv1));
    if (mv0) begin
      chk("r0_sb_pending", 64'(exp0.size() != 0), 64'(1));
      if (exp0.size() != 0) begin
        chk("r0_rsp", 64'({r0_rsp_q, r0_rsp_ov, r0_rsp_z}), 64'(exp0[0]));
        if (r0_rsp_ready) void'(exp0.pop_front());
      end
    end
    if (mv1) begin
      chk("r1_sb_pending", 64'(exp1.size() != 0), 64'(1));
      if (exp1.size() != 0) begin
        chk("r1_rsp", 64'({r1_rsp_q, r1_rsp_ov, r1_rsp_z}), 64'(exp1[0]));
        if (r1_rsp_ready) void'(exp1.pop_front());
      end
    end
    if (g0) begin
      chk("sh_drive0", 64'({sh_a, sh_b, sh_rotate, sh_left, sh_arith}),
          64'({r0_req_a, r0_req_b, r0_req_op}));
      exp0.push_back(ov_en0 ? ov_val0 : ref_op(r0_req_a, r0_req_b, r0_req_op));
      ov_en0 = 1'b0;
    end else if (g1) begin
      chk("sh_drive1", 64'({sh_a, sh_b, sh_rotate, sh_left, sh_arith}),
          64'({r1_req_a, r1_req_b, r1_req_op}));
      exp1.push_back(ov_en1 ? ov_val1 : ref_op(r1_req_a, r1_req_b, r1_req_op));
      ov_en1 = 1'b0;
    end else begin
      chk("sh_idle", 64'({sh_a, sh_b, sh_rotate, sh_left, sh_arith}), 64'(0));
    end
    mv0 = g0 | (mv0 & ~r0_rsp_ready);
    mv1 = g1 | (mv1 & ~r1_rsp_ready);
    if (g0) mptr = 1'b1;
    else if (g1) mptr = 1'b0;
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    r0_req_valid = 1'b0; r0_req_a = '0; r0_req_b = '0; r0_req_op = '0; r0_rsp_ready = 1'b1;
    r1_req_valid = 1'b0; r1_req_a = '0; r1_req_b = '0; r1_req_op = '0; r1_rsp_ready = 1'b1;

    // Reset values
    #1;
    chk("rst_r0", 64'({r0_rsp_valid, r0_rsp_q, r0_rsp_ov, r0_rsp_z}), 64'(0));
    chk("rst_r1", 64'({r1_rsp_valid, r1_rsp_q, r1_rsp_ov, r1_rsp_z}), 64'(0));
    chk("rst_sh", 64'({sh_a, sh_b, sh_rotate, sh_left, sh_arith}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single SRA, one-cycle latency
    r0_req_valid = 1'b1; r0_req_a = 32'h8000_0000; r0_req_b = 5'd4; r0_req_op = SRA;
    ov_en0 = 1'b1; ov_val0 = {32'hF800_0000, 1'b0, 1'b0};
    tick();
    chk("t1_grant", 64'(last_g0), 64'(1));
    r0_req_valid = 1'b0;
    tick();

    // 2: both continuously valid, strict alternation (pointer now favours r1)
    r0_req_valid = 1'b1; r0_req_a = 32'h1; r0_req_b = 5'd31; r0_req_op = SLL;
    r1_req_valid = 1'b1; r1_req_a = 32'h1; r1_req_b = 5'd1;  r1_req_op = ROR;
    for (int i = 0; i < 6; i++) begin
      ov_en0 = 1'b1; ov_val0 = {32'h8000_0000, 1'b0, 1'b0};
      ov_en1 = 1'b1; ov_val1 = {32'h8000_0000, 1'b0, 1'b0};
      tick();
      chk("t2_alt", 64'({last_g0, last_g1}), 64'((i % 2 == 1) ? 2'b10 : 2'b01));
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    tick();

    // 3: overflow and zero flags
    r0_req_valid = 1'b1; r0_req_a = 32'h4000_0000; r0_req_b = 5'd1; r0_req_op = SLA;
    ov_en0 = 1'b1; ov_val0 = {32'h8000_0000, 1'b1, 1'b0};
    r1_req_valid = 1'b1; r1_req_a = 32'h0000_00F0; r1_req_b = 5'd8; r1_req_op = SRL;
    ov_en1 = 1'b1; ov_val1 = {32'h0, 1'b0, 1'b1};
    tick();
    r1_req_valid = 1'b0;
    tick();
    r0_req_valid = 1'b0;
    tick();

    // 4: blocked requester yields, then is served once it drains
    r0_req_valid = 1'b1; r0_req_a = 32'hDEAD_BEEF; r0_req_b = 5'd3; r0_req_op = ROL;
    r0_rsp_ready = 1'b0;
    tick();
    r0_req_valid = 1'b0; r0_req_a = 32'h1234_5678;
    r1_req_valid = 1'b1; r1_req_a = 32'hF000_000F; r1_req_b = 5'd2; r1_req_op = SRA;
    tick();
    r0_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r1_req_a = 32'h0F00_0000 >> i;
      tick();
      chk("t4_yield", 64'({last_g0, last_g1}), 64'(2'b01));
    end
    r0_rsp_ready = 1'b1;
    tick();
    chk("t4_served", 64'({last_g0, last_g1}), 64'(2'b10));
    r1_req_valid = 1'b0;

    // 5: drain-and-refill back to back with no bubble
    for (int i = 0; i < 3; i++) begin
      r0_req_a = 32'hA5A5_0000 + 32'(i); r0_req_b = 5'(i + 1); r0_req_op = SLL;
      tick();
      chk("t5_refill", 64'(last_g0), 64'(1));
    end
    r0_req_valid = 1'b0;
    tick();

    // Random traffic with back-pressure
    for (int i = 0; i < 60; i++) begin
      r0_req_valid = 1'($urandom_range(0, 1)); r1_req_valid = 1'($urandom_range(0, 1));
      r0_req_a = $urandom(); r1_req_a = $urandom();
      r0_req_b = 5'($urandom_range(0, 31)); r1_req_b = 5'($urandom_range(0, 31));
      r0_req_op = 3'($urandom_range(0, 7)); r1_req_op = 3'($urandom_range(0, 7));
      r0_rsp_ready = ($urandom_range(0, 3) != 0); r1_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // 6: asynchronous reset with both slots full, pointer favouring r1
    r0_req_valid = 1'b0; r1_req_valid = 1'b0; r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    tick();
    r1_req_valid = 1'b1; r1_rsp_ready = 1'b0; r0_rsp_ready = 1'b0;
    tick();
    r1_req_valid = 1'b0; r0_req_valid = 1'b1;
    tick();
    r1_req_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'({r0_rsp_valid, r1_rsp_valid}), 64'(0));
    reset_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    r0_req_a = 32'h0000_0100; r0_req_b = 5'd8; r0_req_op = SRL;
    tick();
    chk("t6_first_r0", 64'({last_g0, last_g1}), 64'(2'b10));
    r0_req_valid = 1'b0;
    tick();
    r1_req_valid = 1'b0;
    tick();
    tick();

    chk("sb0_drained", 64'(exp0.size()), 64'(0));
    chk("sb1_drained", 64'(exp1.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
